paralleltoserial_tx: RTL

PARALLELTOSERIAL_TX -- requirements
Module: paralleltoserial_tx

---
 rtl/paralleltoserial_tx.sv | 133 +++++++++++++
 1 files changed

// File: rtl/paralleltoserial_tx.sv
// rtl/paralleltoserial_tx.sv - 8b parallel-to-serial transmitter: comma init, 4-deep input FIFO, idle fill
// Bit order: MSB first by default, LSB first when P2S_LSB_FIRST_EN is defined.
module paralleltoserial_tx (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       data_out,
   output logic       frame_start,
   output logic       active_out
);

   localparam logic [7:0] COMMA = 8'hBC;
   localparam logic [7:0] IDLE  = 8'h7C;

   typedef enum logic [1:0] {
      ST_RST,
      ST_INIT,
      ST_ACTIVE
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  init_cnt_q, init_cnt_d;
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [2:0]  count_q, count_d;
   logic        ready_q, ready_d;
   logic        fs_q, fs_d;
   logic        active_q, active_d;
   logic [7:0]  mem_q [0:3];

   logic        push;
   logic        pop;
   logic        load;
   logic        use_data;
   logic [7:0]  frame_byte;
   logic [7:0]  shifted;

`ifdef P2S_LSB_FIRST_EN
   assign shifted  = {1'b0, shift_q[7:1]};
   assign data_out = shift_q[0];
`else
   assign shifted  = {shift_q[6:0], 1'b0};
   assign data_out = shift_q[7];
`endif

   assign ready_out   = ready_q;
   assign frame_start = fs_q;
   assign active_out  = active_q;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q + 3'd1;
      shift_d    = shifted;
      init_cnt_d = init_cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      pop        = 1'b0;
      frame_byte = COMMA;

      push     = valid_in && ready_q;
      load     = (bit_cnt_q == 3'd7);
      // The fifth load after reset is the first data frame, so it already selects FIFO/idle.
      use_data = (state_q == ST_ACTIVE) ||
                 ((state_q == ST_INIT) && (init_cnt_q == 3'd4));

      case (state_q)
         ST_RST:    state_d = ST_INIT;
         ST_INIT:   if (load && (init_cnt_q == 3'd4)) state_d = ST_ACTIVE;
         ST_ACTIVE: state_d = ST_ACTIVE;
         default:   state_d = ST_RST;
      endcase

      if (load) begin
         if (use_data) begin
            if (count_q != 3'd0) begin
               pop        = 1'b1;
               frame_byte = mem_q[rd_ptr_q];
            end else begin
               frame_byte = IDLE;
            end
         end else begin
            frame_byte = COMMA;
            init_cnt_d = init_cnt_q + 3'd1;
         end
         shift_d = frame_byte;
      end

      if (push) wr_ptr_d = wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
      count_d = count_q + {2'b00, push} - {2'b00, pop};

      ready_d  = (count_d < 3'd4);
      fs_d     = load;
      active_d = (state_d == ST_ACTIVE);
   end

   always_ff @(posedge clk_32f) begin
      if (reset) begin
         state_q    <= ST_RST;
         bit_cnt_q  <= 3'd7;
         shift_q    <= 8'h00;
         init_cnt_q <= 3'd0;
         wr_ptr_q   <= 2'd0;
         rd_ptr_q   <= 2'd0;
         count_q    <= 3'd0;
         ready_q    <= 1'b0;
         fs_q       <= 1'b0;
         active_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         init_cnt_q <= init_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ready_q    <= ready_d;
         fs_q       <= fs_d;
         active_q   <= active_d;
      end
   end

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge clk_32f) begin
      if (!reset && push) mem_q[wr_ptr_q] <= data_in;
   end

endmodule
